// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer: FSM state encodings,
// ALU opcode constants and the bit positions inside the packed flag word.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_NOT = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SLT = 3'd6;
  localparam logic [2:0] OP_EQ  = 3'd7;

  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 1;
  localparam int FLAG_ZERO  = 0;

  function automatic logic [2:0] pack_flags(input logic carry, input logic ovf, input logic zero);
    logic [2:0] f;
    f             = 3'b000;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_operand_sequencer_key_debounce.sv
// Load-button conditioning: 2-flop synchronizer, counting debouncer and a
// registered rising-edge detector producing a single-cycle pulse per press.
module key_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic pulse
);

  localparam logic [7:0] CNT_LAST = 8'(DB_CYCLES - 1);

  logic       r_sync1;
  logic       r_sync2;
  logic       r_level;
  logic       r_level_d;
  logic       r_armed;
  logic [7:0] r_cnt;
  logic [1:0] r_settle;
  logic       w_rise;

  // A key held through reset never arms; a real low level must be seen first.
  assign w_rise = r_level & ~r_level_d & r_armed;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_armed   <= 1'b0;
      r_cnt     <= 8'd0;
      r_settle  <= 2'd0;
      pulse     <= 1'b0;
    end else begin
      r_sync1   <= key_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      pulse     <= w_rise;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= 8'd0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end else begin
        r_cnt <= 8'd0;
      end
      // r_sync2 only reflects the pin two edges after reset release.
      if (r_settle != 2'd2) begin
        r_settle <= r_settle + 2'd1;
      end
      if ((r_settle == 2'd2) && !r_sync2) begin
        r_armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Steps operand A, operand B and opcode from switches into an external ALU on
// successive debounced key presses, then captures the ALU result and flags.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw_data,
  input  logic [2:0] sw_op,
  input  logic       key_load,
  input  logic       clear,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  input  logic       alu_zero,
  output logic [3:0] res_q,
  output logic [2:0] flags_q,
  output logic       res_valid,
  output logic [2:0] state_q
);

  state_t     r_state;
  logic [3:0] r_a;
  logic [3:0] r_b;
  logic [2:0] r_op;
  logic [3:0] r_res;
  logic [2:0] r_flags;
  logic       r_res_valid;
  logic       w_load_pulse;

  key_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_key_debounce (
    .clk    (clk),
    .rst    (rst),
    .key_raw(key_load),
    .pulse  (w_load_pulse)
  );

  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_op    = r_op;
  assign res_q     = r_res;
  assign flags_q   = r_flags;
  assign res_valid = r_res_valid;
  assign state_q   = r_state;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_state     <= S_A;
      r_a         <= 4'd0;
      r_b         <= 4'd0;
      r_op        <= 3'd0;
      r_res       <= 4'd0;
      r_flags     <= 3'd0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      case (r_state)
        S_A: begin
          if (w_load_pulse) begin
            r_a     <= sw_data;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (w_load_pulse) begin
            r_b     <= sw_data;
            r_state <= S_OP;
          end
        end
        S_OP: begin
          if (w_load_pulse) begin
            r_op    <= sw_op;
            r_state <= S_EXEC;
          end
        end
        // The ALU has had a full cycle to settle on the registered operands.
        S_EXEC: begin
          r_res       <= alu_result;
          r_flags     <= pack_flags(alu_carry, alu_overflow, alu_zero);
          r_res_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (w_load_pulse) begin
            r_a     <= sw_data;
            r_state <= S_B;
          end
        end
        default: begin
          r_state <= S_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: constant result table, hand-written corner sequences and
// a randomized run against a press-level model of the sequencer and the ALU.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst, clear, key_load;
  logic [3:0] sw_data;
  logic [2:0] sw_op;
  logic [3:0] alu_a, alu_b, alu_result, res_q;
  logic [2:0] alu_op, flags_q, state_q;
  logic       alu_carry, alu_overflow, alu_zero, res_valid;

  int         n_vec = 0;
  int         n_err = 0;
  int         n_valid = 0;
  int         n_trans = 0;
  logic [2:0] prev_state = 3'd0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DB_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw_data(sw_data), .sw_op(sw_op), .key_load(key_load),
    .clear(clear), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .res_q(res_q), .flags_q(flags_q), .res_valid(res_valid),
    .state_q(state_q)
  );

  // Behavioural ALU: returns {result, carry(borrow on sub), overflow, zero}.
  function automatic logic [6:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, v;
    c = 1'b0; v = 1'b0; r = 4'd0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4];
                  v = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin r = a - b; c = (a < b); v = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {r, c, v, (r == 4'd0)};
  endfunction

  always_comb {alu_result, alu_carry, alu_overflow, alu_zero} = alu_fn(alu_a, alu_b, alu_op);

  always @(negedge clk) begin
    if (res_valid === 1'b1) n_valid++;
    if (state_q !== prev_state) n_trans++;
    prev_state = state_q;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] op);
    sw_data  = d;
    sw_op    = op;
    key_load = 1'b1;
    repeat (DB + 8) tick();
    key_load = 1'b0;
    repeat (DB + 8) tick();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic [2:0] flags;
  } vec_t;

  vec_t       tbl[12];
  logic [3:0] m_a, m_b, m_res, na;
  logic [2:0] m_op, m_flags, m_st, rop;
  logic [6:0] m_alu;
  int         t0, v0, lat, exp_v;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'h7, 4'h1, 3'd0, 4'h8, 3'b010};
    tbl[1]  = '{4'h3, 4'h3, 3'd1, 4'h0, 3'b001};
    tbl[2]  = '{4'h2, 4'h5, 3'd1, 4'hD, 3'b100};
    tbl[3]  = '{4'hF, 4'h1, 3'd0, 4'h0, 3'b101};
    tbl[4]  = '{4'h5, 4'h3, 3'd2, 4'hA, 3'b000};
    tbl[5]  = '{4'hC, 4'hA, 3'd3, 4'h8, 3'b000};
    tbl[6]  = '{4'hC, 4'h3, 3'd4, 4'hF, 3'b000};
    tbl[7]  = '{4'h6, 4'h6, 3'd5, 4'h0, 3'b001};
    tbl[8]  = '{4'h8, 4'h1, 3'd6, 4'h1, 3'b000};
    tbl[9]  = '{4'h7, 4'h8, 3'd6, 4'h0, 3'b001};
    tbl[10] = '{4'h8, 4'h1, 3'd1, 4'h7, 3'b010};
    tbl[11] = '{4'h9, 4'h9, 3'd7, 4'h1, 3'b000};

    rst = 1'b1; clear = 1'b0; key_load = 1'b0; sw_data = 4'd0; sw_op = 3'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_state", 32'(state_q), 32'(S_A));
    check("rst_a", 32'(alu_a), 32'h0);
    check("rst_b", 32'(alu_b), 32'h0);
    check("rst_op", 32'(alu_op), 32'h0);
    check("rst_res", 32'(res_q), 32'h0);
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_valid", 32'(res_valid), 32'h0);
    repeat (4) tick();

    // Long hold: one load, at DB+3 edges after first sampled high.
    t0 = n_trans; lat = 0;
    sw_data = 4'hA; key_load = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (state_q != 3'(S_A)) begin lat = i; break; end
    end
    check("latency_ticks", 32'(lat), 32'(DB + 4));
    repeat (20 - lat) tick();
    key_load = 1'b0;
    repeat (DB + 8) tick();
    check("hold_one_pulse", 32'(n_trans - t0), 32'd1);
    check("hold_a", 32'(alu_a), 32'hA);
    check("hold_state", 32'(state_q), 32'(S_B));

    // Bouncy 3-high/3-low/3-high must be filtered out.
    do_clear();
    t0 = n_trans;
    key_load = 1'b1; repeat (3) tick();
    key_load = 1'b0; repeat (3) tick();
    key_load = 1'b1; repeat (3) tick();
    key_load = 1'b0; repeat (DB + 8) tick();
    check("bounce_state", 32'(state_q), 32'(S_A));
    check("bounce_no_trans", 32'(n_trans - t0), 32'd0);

    for (int i = 0; i < 12; i++) begin
      do_clear();
      v0 = n_valid;
      press(tbl[i].a, 3'd0);
      press(tbl[i].b, 3'd0);
      press(4'd0, tbl[i].op);
      check("tbl_valid_once", 32'(n_valid - v0), 32'd1);
      check("tbl_res", 32'(res_q), 32'(tbl[i].res));
      check("tbl_flags", 32'(flags_q), 32'(tbl[i].flags));
      check("tbl_state_done", 32'(state_q), 32'(S_DONE));
      na = ~tbl[i].a;
      press(na, 3'd0);
      check("tbl_new_a", 32'(alu_a), 32'(na));
      check("tbl_keep_b", 32'(alu_b), 32'(tbl[i].b));
      check("tbl_keep_op", 32'(alu_op), 32'(tbl[i].op));
      check("tbl_state_b", 32'(state_q), 32'(S_B));
      check("tbl_res_hold", 32'(res_q), 32'(tbl[i].res));
      check("tbl_flags_hold", 32'(flags_q), 32'(tbl[i].flags));
    end

    // clear coincident with the load pulse while in S_OP.
    press(4'h2, 3'd0);
    check("pre_clear_state", 32'(state_q), 32'(S_OP));
    v0 = n_valid;
    sw_op = 3'd3; key_load = 1'b1;
    repeat (DB + 3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_state", 32'(state_q), 32'(S_A));
    check("clr_a", 32'(alu_a), 32'h0);
    check("clr_b", 32'(alu_b), 32'h0);
    check("clr_op", 32'(alu_op), 32'h0);
    check("clr_res", 32'(res_q), 32'h0);
    check("clr_flags", 32'(flags_q), 32'h0);
    repeat (8) tick();
    key_load = 1'b0;
    repeat (DB + 8) tick();
    check("clr_pulse_dropped", 32'(state_q), 32'(S_A));
    check("clr_no_valid", 32'(n_valid - v0), 32'd0);

    // Reset during S_EXEC, key held through reset.
    press(4'h9, 3'd0);
    press(4'h4, 3'd0);
    v0 = n_valid;
    sw_op = 3'd0; key_load = 1'b1;
    repeat (DB + 4) tick();
    check("exec_state", 32'(state_q), 32'(S_EXEC));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstx_state", 32'(state_q), 32'(S_A));
    check("rstx_res", 32'(res_q), 32'h0);
    check("rstx_a", 32'(alu_a), 32'h0);
    repeat (DB + 12) tick();
    check("rstx_no_valid", 32'(n_valid - v0), 32'd0);
    check("held_key_no_pulse", 32'(state_q), 32'(S_A));
    key_load = 1'b0;
    repeat (DB + 8) tick();
    press(4'h3, 3'd0);
    check("repress_state", 32'(state_q), 32'(S_B));
    check("repress_a", 32'(alu_a), 32'h3);

    // Randomized presses/clears against a press-level model.
    do_clear();
    m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_res = 4'd0; m_flags = 3'd0; m_st = 3'd0;
    for (int i = 0; i < 60; i++) begin
      v0 = n_valid; exp_v = 0;
      if ($urandom_range(0, 9) == 0) begin
        do_clear();
        m_a = 4'd0; m_b = 4'd0; m_op = 3'd0; m_res = 4'd0; m_flags = 3'd0; m_st = 3'd0;
      end else begin
        na  = 4'($urandom_range(0, 15));
        rop = 3'($urandom_range(0, 7));
        press(na, rop);
        case (m_st)
          3'd0: begin m_a = na; m_st = 3'd1; end
          3'd1: begin m_b = na; m_st = 3'd2; end
          3'd2: begin
            m_op = rop; m_alu = alu_fn(m_a, m_b, rop);
            m_res = m_alu[6:3]; m_flags = m_alu[2:0]; m_st = 3'd4; exp_v = 1;
          end
          default: begin m_a = na; m_st = 3'd1; end
        endcase
      end
      check("rnd_state", 32'(state_q), 32'(m_st));
      check("rnd_a", 32'(alu_a), 32'(m_a));
      check("rnd_b", 32'(alu_b), 32'(m_b));
      check("rnd_op", 32'(alu_op), 32'(m_op));
      check("rnd_res", 32'(res_q), 32'(m_res));
      check("rnd_flags", 32'(flags_q), 32'(m_flags));
      check("rnd_valid", 32'(n_valid - v0), 32'(exp_v));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
